snoop_bus_arbiter: RTL and testbench

- Arbitrates the shared snooping bus between NUM_CPU cache controllers in the MESI coherence system.
- Grants one requester at a time in round-robin order and broadcasts its miss or invalidate command to every snooper's bus-side MESI machine.
- Collects each snooper's memory-abort response.
- Then either runs a main-memory access, waits out a cache-to-cache writeback, or completes immediately (invalidate), and signals completion back to the requester.

---
 rtl/snoop_bus_arbiter.sv | 269 ++++++++++++++++++++++++++
 tb/tb_snoop_bus_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snoop_bus_arbiter.sv
// Round-robin arbiter for the MESI snooping bus: grant, broadcast, collect aborts,
// then memory access, cache-to-cache writeback wait, or immediate completion.
// Define BUS_TIMEOUT_EN to add a memory-wait timeout that raises bus_error.

module snoop_bus_arbiter #(
    parameter int NUM_CPU   = 4,
    parameter int AW        = 8,
    parameter int WB_CYCLES = 2,
    parameter int TIMEOUT   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_CPU-1:0]    req,
    input  logic [2*NUM_CPU-1:0]  cmd_in,
    input  logic [AW*NUM_CPU-1:0] addr_in,
    output logic [NUM_CPU-1:0]    grant,
    output logic                  bus_valid,
    output logic                  bus_read_miss,
    output logic                  bus_write_miss,
    output logic                  bus_invalidate,
    output logic [AW-1:0]         bus_addr,
    input  logic [NUM_CPU-1:0]    snoop_abort,
    output logic                  mem_req,
    output logic [AW-1:0]         mem_addr,
    input  logic                  mem_ready,
    output logic [NUM_CPU-1:0]    done,
    output logic                  busy,
    output logic                  bus_error
);

    localparam int IW  = (NUM_CPU > 1) ? $clog2(NUM_CPU) : 1;
    localparam int WBW = $clog2(WB_CYCLES + 1);
    localparam logic [NUM_CPU-1:0] ONE_HOT0 = NUM_CPU'(1);
    localparam logic [IW-1:0]      LAST_IDX = IW'(NUM_CPU - 1);
    localparam logic [1:0] CMD_RD  = 2'b01;
    localparam logic [1:0] CMD_WR  = 2'b10;
    localparam logic [1:0] CMD_INV = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_GRANT, S_SNOOP, S_MEM_WAIT, S_WB, S_DONE
    } state_t;

    if (NUM_CPU < 2 || NUM_CPU > 8 || WB_CYCLES < 1 || TIMEOUT < 1) begin : g_param_check
        $error("snoop_bus_arbiter: illegal parameter value");
    end

    // Per-CPU views of the flattened request buses
    logic [1:0]         cmd_arr  [NUM_CPU];
    logic [AW-1:0]      addr_arr [NUM_CPU];
    logic [NUM_CPU-1:0] eligible;

    for (genvar gi = 0; gi < NUM_CPU; gi++) begin : g_cpu
        assign cmd_arr[gi]  = cmd_in[2*gi +: 2];
        assign addr_arr[gi] = addr_in[AW*gi +: AW];
        assign eligible[gi] = req[gi] & (cmd_in[2*gi +: 2] != 2'b00);
    end

    state_t             state_q, state_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [IW-1:0]      owner_q, owner_d;
    logic [1:0]         cmd_q, cmd_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [WBW-1:0]     wb_cnt_q, wb_cnt_d;
    logic [NUM_CPU-1:0] abort_seen;

    logic [NUM_CPU-1:0] grant_q, grant_d;
    logic               bus_valid_q, bus_valid_d;
    logic               bus_rd_q, bus_rd_d;
    logic               bus_wr_q, bus_wr_d;
    logic               bus_inv_q, bus_inv_d;
    logic [AW-1:0]      bus_addr_q, bus_addr_d;
    logic               mem_req_q, mem_req_d;
    logic [AW-1:0]      mem_addr_q, mem_addr_d;
    logic [NUM_CPU-1:0] done_q, done_d;
    logic               busy_q, busy_d;

`ifdef BUS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          timeout_hit;
    logic          bus_error_q, bus_error_d;
`endif

    // Round-robin search: first eligible requester at or above the pointer, wrapping
    logic          sel_found;
    logic [IW-1:0] sel_idx;
    int            cand;

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        for (int k = 0; k < NUM_CPU; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= NUM_CPU) begin
                cand = cand - NUM_CPU;
            end
            if (!sel_found && eligible[cand[IW-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[IW-1:0];
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            cmd_q       <= '0;
            addr_q      <= '0;
            wb_cnt_q    <= '0;
            grant_q     <= '0;
            bus_valid_q <= 1'b0;
            bus_rd_q    <= 1'b0;
            bus_wr_q    <= 1'b0;
            bus_inv_q   <= 1'b0;
            bus_addr_q  <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            done_q      <= '0;
            busy_q      <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            tmo_cnt_q   <= '0;
            bus_error_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            wb_cnt_q    <= wb_cnt_d;
            grant_q     <= grant_d;
            bus_valid_q <= bus_valid_d;
            bus_rd_q    <= bus_rd_d;
            bus_wr_q    <= bus_wr_d;
            bus_inv_q   <= bus_inv_d;
            bus_addr_q  <= bus_addr_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
`ifdef BUS_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
            bus_error_q <= bus_error_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        cmd_d      = cmd_q;
        addr_d     = addr_q;
        wb_cnt_d   = wb_cnt_q;
        // The owner may also be a snooper of its own broadcast; its abort is meaningless
        abort_seen = snoop_abort & ~grant_q;
`ifdef BUS_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
        timeout_hit = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (sel_found) begin
                    state_d = S_GRANT;
                    owner_d = sel_idx;
                    cmd_d   = cmd_arr[sel_idx];
                    addr_d  = addr_arr[sel_idx];
                end
            end
            S_GRANT: state_d = S_SNOOP;
            S_SNOOP: begin
                if (cmd_q == CMD_INV) begin
                    state_d = S_DONE;
                end else if (abort_seen != '0) begin
                    state_d  = S_WB;
                    wb_cnt_d = WBW'(WB_CYCLES);
                end else begin
                    state_d = S_MEM_WAIT;
`ifdef BUS_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                end
            end
            S_MEM_WAIT: begin
                if (mem_ready) begin
                    state_d = S_DONE;
`ifdef BUS_TIMEOUT_EN
                end else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
                    state_d     = S_DONE;
                    timeout_hit = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
`endif
                end
            end
            S_WB: begin
                if (wb_cnt_q <= WBW'(1)) begin
                    state_d = S_DONE;
                end else begin
                    wb_cnt_d = wb_cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                ptr_d   = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: every output is a flop loaded from the upcoming state
    always_comb begin
        grant_d     = '0;
        bus_valid_d = 1'b0;
        bus_rd_d    = 1'b0;
        bus_wr_d    = 1'b0;
        bus_inv_d   = 1'b0;
        bus_addr_d  = bus_addr_q;
        mem_req_d   = 1'b0;
        mem_addr_d  = mem_addr_q;
        done_d      = '0;
        busy_d      = (state_d != S_IDLE);
        if (state_d != S_IDLE) begin
            grant_d = ONE_HOT0 << owner_d;
        end
        case (state_d)
            S_SNOOP: begin
                bus_valid_d = 1'b1;
                bus_rd_d    = (cmd_d == CMD_RD);
                bus_wr_d    = (cmd_d == CMD_WR);
                bus_inv_d   = (cmd_d == CMD_INV);
                bus_addr_d  = addr_d;
            end
            S_MEM_WAIT: begin
                mem_req_d  = 1'b1;
                mem_addr_d = addr_d;
            end
            S_DONE: begin
                done_d = ONE_HOT0 << owner_d;
            end
            default: ;
        endcase
`ifdef BUS_TIMEOUT_EN
        bus_error_d = timeout_hit;
`endif
    end

    assign grant          = grant_q;
    assign bus_valid      = bus_valid_q;
    assign bus_read_miss  = bus_rd_q;
    assign bus_write_miss = bus_wr_q;
    assign bus_invalidate = bus_inv_q;
    assign bus_addr       = bus_addr_q;
    assign mem_req        = mem_req_q;
    assign mem_addr       = mem_addr_q;
    assign done           = done_q;
    assign busy           = busy_q;
`ifdef BUS_TIMEOUT_EN
    assign bus_error      = bus_error_q;
`else
    assign bus_error      = 1'b0;
`endif

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Scoreboard bench for snoop_bus_arbiter: a transaction-level model predicts grant
// order and completion timing; a monitor compares each bus transaction as it happens.

module tb_snoop_bus_arbiter;

    localparam int N   = 4;
    localparam int AW  = 8;
    localparam int WB  = 2;
    localparam int TMO = 16;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req = '0;
    logic [2*N-1:0]  cmd_in = '0;
    logic [AW*N-1:0] addr_in = '0;
    logic [N-1:0]    snoop_abort = '0;
    logic            mem_ready = 1'b0;
    logic [N-1:0]    grant;
    logic            bus_valid, bus_read_miss, bus_write_miss, bus_invalidate;
    logic [AW-1:0]   bus_addr, mem_addr;
    logic            mem_req, busy, bus_error;
    logic [N-1:0]    done;

    snoop_bus_arbiter #(.NUM_CPU(N), .AW(AW), .WB_CYCLES(WB), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .req(req), .cmd_in(cmd_in), .addr_in(addr_in),
        .grant(grant), .bus_valid(bus_valid), .bus_read_miss(bus_read_miss),
        .bus_write_miss(bus_write_miss), .bus_invalidate(bus_invalidate),
        .bus_addr(bus_addr), .snoop_abort(snoop_abort), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_ready(mem_ready), .done(done), .busy(busy),
        .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         owner;
        logic [1:0] cmd;
        logic [AW-1:0] addr;
        bit         first;
        int         span;   // cycles from bus_valid to done
        int         nmem;   // mem_req cycles expected
        bit         err;
    } exp_t;

    typedef struct {
        logic [N-1:0]    rq;
        logic [2*N-1:0]  cmd;
        logic [AW*N-1:0] addr;
    } batch_t;

    exp_t     exp_q[$];
    batch_t   batch_q[$];
    logic [N-1:0] plan_abort_q[$];
    int       plan_lat_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    bit mon_busy = 0;
    int issue_cyc = 0;
    int outstanding = 0;

    int         model_ptr = 0;
    logic [N-1:0] b_abort [N];
    int         b_lat [N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Responder: owns every DUT input except reset; changes them on the falling edge
    initial begin : responder
        logic [N-1:0] prev_grant;
        int cur_lat, mcnt, hold, oi;
        batch_t bt;
        prev_grant = '0; cur_lat = 0; mcnt = 0; hold = 0; oi = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                req = '0; cmd_in = '0; addr_in = '0; snoop_abort = '0; mem_ready = 1'b0;
                outstanding = 0; mcnt = 0; hold = 0; prev_grant = '0;
            end else begin
                if (done != '0) begin
                    req = req & ~done;
                    outstanding--;
                    if (outstanding <= 0) begin
                        outstanding = 0; req = '0; cmd_in = '0; addr_in = '0;
                    end
                end
                if (grant != '0 && prev_grant == '0 && $urandom_range(1, 0) == 1) begin
                    // Owner scribbles on its request lines; the latched values must win
                    for (int i = 0; i < N; i++) if (grant[i]) oi = i;
                    cmd_in[2*oi +: 2]   = 2'($urandom_range(3, 1));
                    addr_in[AW*oi +: AW] = AW'($urandom);
                    req[oi] = 1'($urandom_range(1, 0));
                end
                prev_grant = grant;
                if (bus_valid && plan_abort_q.size() > 0) begin
                    snoop_abort = plan_abort_q.pop_front();
                    cur_lat     = plan_lat_q.pop_front();
                end else begin
                    snoop_abort = N'($urandom);
                end
                if (mem_req) begin
                    mcnt++;
                    mem_ready = (mcnt == cur_lat);
                end else begin
                    mcnt = 0;
                    mem_ready = 1'($urandom_range(1, 0));
                end
                if (hold > 0) begin
                    hold--;
                    if (hold == 0) begin req = '0; cmd_in = '0; addr_in = '0; end
                end else if (outstanding == 0 && !busy && req == '0 && batch_q.size() > 0) begin
                    bt = batch_q.pop_front();
                    req = bt.rq; cmd_in = bt.cmd; addr_in = bt.addr;
                    issue_cyc = cyc;
                    for (int i = 0; i < N; i++)
                        if (bt.rq[i] && bt.cmd[2*i +: 2] != 2'b00) outstanding++;
                    if (outstanding == 0) hold = 4;
                end
            end
        end
    end

    // Monitor: pops the next expected transaction and follows it on the bus
    initial begin : monitor
        exp_t e;
        logic [N-1:0] oh;
        logic [2:0] strb;
        int b, d, nmem, extra, last_done, gwant;
        bit found;
        last_done = 0;
        forever begin
            wait (exp_q.size() != 0);
            mon_busy = 1;
            e = exp_q.pop_front();
            oh = '0; oh[e.owner] = 1'b1;
            strb = (e.cmd == 2'b01) ? 3'b001 : (e.cmd == 2'b10) ? 3'b010 : 3'b100;
            found = 0;
            for (int w = 0; w < 300 && !found; w++) begin
                @(posedge clk); #1;
                if (grant != '0) found = 1;
            end
            chk("grant_seen", 32'(found), 1);
            if (found) begin
                gwant = e.first ? issue_cyc + 1 : last_done + 2;
                chk("grant_owner", 32'(grant), 32'(oh));
                chk("grant_cycle", cyc, gwant);
                @(posedge clk); #1;
                b = cyc;
                chk("bus_valid", 32'(bus_valid), 1);
                chk("bus_strobe", 32'({bus_invalidate, bus_write_miss, bus_read_miss}), 32'(strb));
                chk("bus_addr", 32'(bus_addr), 32'(e.addr));
                chk("grant_hold", 32'(grant), 32'(oh));
                found = 0; nmem = 0; extra = 0;
                for (int w = 0; w < 200 && !found; w++) begin
                    @(posedge clk); #1;
                    if (done != '0) found = 1;
                    else begin
                        if (mem_req) begin
                            nmem++;
                            chk("mem_addr", 32'(mem_addr), 32'(e.addr));
                        end
                        if (bus_valid || bus_error) extra++;
                    end
                end
                chk("done_seen", 32'(found), 1);
                if (found) begin
                    d = cyc;
                    $display("txn cpu%0d cmd=%0d addr=%02h span=%0d mem=%0d err=%0b",
                             e.owner, e.cmd, e.addr, d - b, nmem, bus_error);
                    chk("done_owner", 32'(done), 32'(oh));
                    chk("done_grant", 32'(grant), 32'(oh));
                    chk("done_span", d - b, e.span);
                    chk("mem_cycles", nmem, e.nmem);
                    chk("bus_error", 32'(bus_error), 32'(e.err));
                    chk("done_memreq", 32'(mem_req), 0);
                    chk("stray_strobe", extra, 0);
                    @(posedge clk); #1;
                    chk("post_grant", 32'(grant), 0);
                    chk("post_done", 32'(done), 0);
                    chk("post_busy", 32'(busy), 0);
                    last_done = d;
                end
            end
            mon_busy = 0;
        end
    end

    // Reference model: orders the eligible requesters round-robin from the pointer
    task automatic run_batch(input logic [N-1:0] rq, input logic [2*N-1:0] cmd,
                             input logic [AW*N-1:0] addr);
        batch_t bt;
        exp_t e;
        logic [N-1:0] masked;
        int i, last;
        bit first, ok;
        first = 1; last = -1;
        for (int k = 0; k < N; k++) begin
            i = (model_ptr + k) % N;
            if (rq[i] && cmd[2*i +: 2] != 2'b00) begin
                e.owner = i; e.cmd = cmd[2*i +: 2]; e.addr = addr[AW*i +: AW];
                e.first = first; e.err = 0; e.nmem = 0;
                masked = b_abort[i]; masked[i] = 1'b0;
                if (e.cmd == 2'b11) e.span = 1;
                else if (masked != '0) e.span = 1 + WB;
                else begin
`ifdef BUS_TIMEOUT_EN
                    if (b_lat[i] > TMO) begin
                        e.span = 1 + TMO; e.nmem = TMO; e.err = 1;
                    end else begin
                        e.span = 1 + b_lat[i]; e.nmem = b_lat[i];
                    end
`else
                    e.span = 1 + b_lat[i]; e.nmem = b_lat[i];
`endif
                end
                exp_q.push_back(e);
                plan_abort_q.push_back(b_abort[i]);
                plan_lat_q.push_back(b_lat[i]);
                first = 0; last = i;
            end
        end
        if (last >= 0) model_ptr = (last + 1) % N;
        bt.rq = rq; bt.cmd = cmd; bt.addr = addr;
        batch_q.push_back(bt);
        if (last < 0) begin
            for (int w = 0; w < 50 && batch_q.size() != 0; w++) begin @(posedge clk); #1; end
            repeat (3) begin @(posedge clk); #1; end
            chk("ignored_grant", 32'(grant), 0);
            chk("ignored_busy", 32'(busy), 0);
        end
        ok = 0;
        for (int w = 0; w < 3000 && !ok; w++) begin
            @(posedge clk); #1;
            ok = (exp_q.size() == 0 && !mon_busy && batch_q.size() == 0 && req == '0 && !busy);
        end
        chk("batch_complete", 32'(ok), 1);
    endtask

    task automatic rand_plan();
        int r;
        for (int i = 0; i < N; i++) begin
            r = $urandom_range(3, 0);
            b_abort[i] = (r == 0) ? '0 : (r == 1) ? N'(1 << i) : N'($urandom);
            b_lat[i] = $urandom_range(5, 1);
`ifdef BUS_TIMEOUT_EN
            r = $urandom_range(9, 0);
            if (r == 0) b_lat[i] = TMO + 3;
            else if (r == 1) b_lat[i] = TMO;
`endif
        end
    endtask

    initial begin : main
        logic [2*N-1:0]  cmd;
        logic [AW*N-1:0] addr;
        bit seen;
        repeat (3) begin @(posedge clk); #1; end
        chk("rst_grant", 32'(grant), 0);
        chk("rst_bus", 32'({bus_valid, bus_read_miss, bus_write_miss, bus_invalidate}), 0);
        chk("rst_addr", 32'({bus_addr, mem_addr}), 0);
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_done_busy_err", 32'({done, busy, bus_error}), 0);
        reset = 1'b0;
        model_ptr = 0;

        for (int i = 0; i < N; i++) begin b_abort[i] = '0; b_lat[i] = 1; end
        b_lat[0] = 3;
        run_batch(4'b0001, 8'b00_00_00_01, 32'h0000_003C);

        rand_plan();
        run_batch(4'b1111, 8'b11_11_11_11, 32'h44_33_22_11);

        b_abort[2] = 4'b0010; b_lat[2] = 1;
        run_batch(4'b0100, 8'b00_10_00_00, 32'h00_9A_00_00);

        b_abort[1] = 4'b0010; b_lat[1] = 2;
        run_batch(4'b0010, 8'b00_00_01_00, 32'h00_00_5B_00);

        run_batch(4'b1010, 8'b00_11_00_01, 32'hA1_B2_C3_D4);

        for (int t = 0; t < 40; t++) begin
            rand_plan();
            cmd  = 8'($urandom);
            addr = $urandom;
            run_batch(N'($urandom), cmd, addr);
        end

`ifdef BUS_TIMEOUT_EN
        b_abort[0] = '0; b_lat[0] = 1000;
        run_batch(4'b0001, 8'b00_00_00_10, 32'h0000_0077);
`endif

        // Reset during MEM_WAIT: the CPU1 read miss must vanish without a done pulse
        b_abort[2] = '0; b_lat[2] = 1;
        run_batch(4'b0100, 8'b00_11_00_00, 32'h00_66_00_00);
        plan_abort_q.push_back('0);
        plan_lat_q.push_back(1000);
        batch_q.push_back('{rq: 4'b0010, cmd: 8'b00_00_01_00, addr: 32'h0000_5500});
        seen = 0;
        for (int w = 0; w < 50 && !seen; w++) begin
            @(posedge clk); #1;
            if (mem_req) seen = 1;
            if (done != '0) chk("rst_txn_no_done", 32'(done), 0);
        end
        chk("rst_memwait_reached", 32'(seen), 1);
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_grant", 32'(grant), 0);
        chk("midrst_mem_req", 32'(mem_req), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_done", 32'(done), 0);
        reset = 1'b0;
        model_ptr = 0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("postrst_idle", 32'({grant, done, busy}), 0);
        end
        for (int i = 0; i < N; i++) begin b_abort[i] = '0; b_lat[i] = 1; end
        run_batch(4'b1111, 8'b11_11_11_11, 32'h0D_0C_0B_0A);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
